piradip_ram_port_arbiter: RTL

Shares one port of the team's true-dual-port RAM between NUM_CLIENTS requesters using round-robin arbitration with bounded burst locking. It drives the RAM port signals (en/we/addr/wdata), tracks in-flight reads through a READ_LATENCY-deep pipeline, and returns rdata with a one-hot per-client rvalid. It sits between DMA/control engines and a single RAM port, which runs in that port's clock domain.

---
 rtl/piradip_ram_port_arbiter_pkg.sv | 31 +++
 rtl/piradip_ram_port_arbiter_if.sv | 33 +++
 rtl/piradip_rd_tracker.sv | 45 ++++
 rtl/piradip_ram_port_arbiter.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/piradip_ram_port_arbiter_pkg.sv
// Shared types and helpers for the RAM port arbiter.
//   rd_track_t : one read-tracking pipeline entry {valid, owner}
//   rr_pick    : round-robin one-hot pick starting at ptr
//   MAX_CLIENTS: upper bound on requesters; client indices fit in 3 bits
package piradip_ram_arb_pkg;

  localparam int unsigned MAX_CLIENTS = 8;

  typedef struct packed {
    logic       valid;
    logic [2:0] owner;
  } rd_track_t;

  // Request bits at or above the real client count must be zero. A plain
  // modulo-8 scan then visits requesters in the same order as a
  // modulo-NUM_CLIENTS scan, so the client count is not needed here.
  function automatic logic [MAX_CLIENTS-1:0] rr_pick(input logic [MAX_CLIENTS-1:0] req,
                                                     input logic [2:0]             ptr);
    logic [MAX_CLIENTS-1:0] pick;
    logic [2:0]             idx;
    pick = '0;
    for (int unsigned i = 0; i < MAX_CLIENTS; i++) begin
      idx = ptr + 3'(i);
      if (req[idx] && (pick == '0)) begin
        pick[idx] = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/piradip_ram_port_arbiter_if.sv
// Client-side bus of the RAM port arbiter.
//   req/lock/we : per-client request, keep-grant request, write enable
//   addr/wdata  : per-client address and write data, client 0 in the LSBs
//   gnt         : one-hot combinational grant
//   rvalid      : one-hot registered read-data-valid
//   rdata       : read data broadcast to all clients
// master: the client side; slave: the arbiter.
interface piradip_ram_port_arbiter_if #(
  parameter int unsigned NUM_CLIENTS = 2,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 10
);

  logic [NUM_CLIENTS-1:0]            req;
  logic [NUM_CLIENTS-1:0]            lock;
  logic [NUM_CLIENTS-1:0]            we;
  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] addr;
  logic [NUM_CLIENTS*DATA_WIDTH-1:0] wdata;
  logic [NUM_CLIENTS-1:0]            gnt;
  logic [NUM_CLIENTS-1:0]            rvalid;
  logic [DATA_WIDTH-1:0]             rdata;

  modport master (
    output req, lock, we, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, lock, we, addr, wdata,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/piradip_rd_tracker.sv
// Read-return tracker: a READ_LATENCY-deep shift pipeline of {valid, owner}
// entries aligned with the RAM read latency, producing one-hot rvalid.
//   clk, rst    : port clock, synchronous active-high reset
//   issue       : a read is presented to the RAM this cycle
//   issue_owner : index of the client issuing that read
//   rvalid      : one-hot read-data-valid at the pipeline output
module piradip_rd_tracker
  import piradip_ram_arb_pkg::*;
#(
  parameter int unsigned NUM_CLIENTS  = 2,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   issue,
  input  logic [2:0]             issue_owner,
  output logic [NUM_CLIENTS-1:0] rvalid
);

  rd_track_t pipe_q [READ_LATENCY];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0] <= '{valid: issue, owner: issue_owner};
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  // Masked by rst so a read that reaches the output during the reset cycle
  // is discarded rather than returned.
  always_comb begin
    rvalid = '0;
    for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
      rvalid[i] = !rst && pipe_q[READ_LATENCY-1].valid &&
                  (pipe_q[READ_LATENCY-1].owner == 3'(i));
    end
  end

endmodule

// File: rtl/piradip_ram_port_arbiter.sv
// Shares one RAM port between NUM_CLIENTS requesters: round-robin grant with
// bounded burst locking, combinational RAM drive from the granted client and
// registered one-hot read return.
//   clk, rst  : port clock, synchronous active-high reset
//   bus       : client bus (req/lock/we/addr/wdata in, gnt/rvalid/rdata out)
//   ram_en/ram_we/ram_addr/ram_wdata : to the RAM port
//   ram_rdata : from the RAM port, passed through to bus.rdata
module piradip_ram_port_arbiter
  import piradip_ram_arb_pkg::*;
#(
  parameter int unsigned NUM_CLIENTS  = 2,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 10,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned LOCK_MAX     = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  piradip_ram_port_arbiter_if.slave bus,
  output logic                      ram_en,
  output logic                      ram_we,
  output logic [ADDR_WIDTH-1:0]     ram_addr,
  output logic [DATA_WIDTH-1:0]     ram_wdata,
  input  logic [DATA_WIDTH-1:0]     ram_rdata
);

  localparam logic [7:0] LOCK_MAX_C = 8'(LOCK_MAX);
  localparam logic [2:0] LAST_IDX   = 3'(NUM_CLIENTS - 1);

  logic [2:0] ptr_q, ptr_d;
  logic       lock_valid_q, lock_valid_d;
  logic [2:0] lock_owner_q, lock_owner_d;
  logic [7:0] lock_cnt_q, lock_cnt_d;

  logic [MAX_CLIENTS-1:0] req_ext;
  logic [NUM_CLIENTS-1:0] gnt;
  logic [NUM_CLIENTS-1:0] rvalid;
  logic [2:0]             gnt_idx;
  logic [2:0]             next_ptr;
  logic [7:0]             cnt_base;
  logic                   gnt_lock;
  logic                   lock_hold;
  logic                   rd_issue;

  assign req_ext   = MAX_CLIENTS'(bus.req);
  assign lock_hold = lock_valid_q && req_ext[lock_owner_q] && (lock_cnt_q < LOCK_MAX_C);

  // Grant: a live, unexpired lock wins; otherwise round-robin from ptr.
  always_comb begin
    gnt = '0;
    if (!rst) begin
      if (lock_hold) begin
        for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
          gnt[i] = (lock_owner_q == 3'(i));
        end
      end else begin
        gnt = NUM_CLIENTS'(rr_pick(req_ext, ptr_q));
      end
    end
  end

  // RAM drive muxed from the granted client; zeros when idle.
  always_comb begin
    gnt_idx   = '0;
    gnt_lock  = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
      if (gnt[i]) begin
        gnt_idx   = 3'(i);
        gnt_lock  = bus.lock[i];
        ram_we    = bus.we[i];
        ram_addr  = bus.addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        ram_wdata = bus.wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign ram_en    = |gnt;
  assign bus.gnt   = gnt;
  assign bus.rdata = ram_rdata;
  assign next_ptr  = (gnt_idx == LAST_IDX) ? 3'd0 : gnt_idx + 3'd1;

  always_comb begin
    ptr_d        = ptr_q;
    lock_valid_d = lock_valid_q;
    lock_owner_d = lock_owner_q;
    lock_cnt_d   = lock_cnt_q;
    // A new owner starts counting from zero; the current owner continues.
    cnt_base = (lock_valid_q && (lock_owner_q == gnt_idx)) ? lock_cnt_q : 8'd0;
    if (lock_valid_q && !req_ext[lock_owner_q]) begin
      lock_valid_d = 1'b0;
      lock_cnt_d   = '0;
    end
    if (ram_en) begin
      if (gnt_lock && (cnt_base < LOCK_MAX_C)) begin
        lock_valid_d = 1'b1;
        lock_owner_d = gnt_idx;
        lock_cnt_d   = cnt_base + 8'd1;
        // Last locked grant: move ptr past the owner so the timeout
        // arbitration round-robins from the next client.
        if (lock_cnt_d == LOCK_MAX_C) begin
          ptr_d = next_ptr;
        end
      end else begin
        lock_valid_d = 1'b0;
        lock_cnt_d   = '0;
        ptr_d        = next_ptr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q        <= '0;
      lock_valid_q <= 1'b0;
      lock_owner_q <= '0;
      lock_cnt_q   <= '0;
    end else begin
      ptr_q        <= ptr_d;
      lock_valid_q <= lock_valid_d;
      lock_owner_q <= lock_owner_d;
      lock_cnt_q   <= lock_cnt_d;
    end
  end

  assign rd_issue = ram_en & ~ram_we;

  piradip_rd_tracker #(
    .NUM_CLIENTS (NUM_CLIENTS),
    .READ_LATENCY(READ_LATENCY)
  ) u_rd_tracker (
    .clk        (clk),
    .rst        (rst),
    .issue      (rd_issue),
    .issue_owner(gnt_idx),
    .rvalid     (rvalid)
  );

  assign bus.rvalid = rvalid;

endmodule
